// File: rtl/product_frame_accumulator_pkg.sv
// rtl/product_frame_accumulator_pkg.sv - shared states, defaults and width helper for the frame accumulator
package product_frame_accumulator_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam int COUNT_DEFAULT = 8;

  // Sum of 2**log2_count unsigned 8-bit products never exceeds this width.
  function automatic int sum_width(input int log2_count);
    return 8 + log2_count;
  endfunction

endpackage

// File: rtl/product_frame_accumulator_frame_stat_datapath.sv
// rtl/product_frame_accumulator_frame_stat_datapath.sv - accumulator, running max and statistics output registers
module frame_stat_datapath
  import product_frame_accumulator_pkg::*;
#(
  parameter int LOG2_COUNT = 3,
  parameter int SUM_W      = sum_width(LOG2_COUNT)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             load,
  input  logic             accum,
  input  logic             finish,
  input  logic             restart,
  input  logic [7:0]       product,
  output logic [SUM_W-1:0] sum,
  output logic [7:0]       avg,
  output logic [7:0]       max_o
);

  logic [SUM_W-1:0] acc_q, acc_d;
  logic [7:0]       max_r_q, max_r_d;
  logic [SUM_W-1:0] sum_q, sum_d;
  logic [7:0]       avg_q, avg_d;
  logic [7:0]       max_out_q, max_out_d;

  logic [SUM_W-1:0] acc_next;
  logic [7:0]       max_next;

  // Running sum/max including the current product; statistics load from these on the last accept.
  always_comb begin
    acc_next  = acc_q + {{(SUM_W-8){1'b0}}, product};
    max_next  = (product > max_r_q) ? product : max_r_q;

    acc_d     = acc_q;
    max_r_d   = max_r_q;
    sum_d     = sum_q;
    avg_d     = avg_q;
    max_out_d = max_out_q;

    if (clear) begin
      acc_d   = '0;
      max_r_d = '0;
    end else if (restart) begin
      acc_d   = '0;
    end else if (load) begin
      acc_d   = {{(SUM_W-8){1'b0}}, product};
      max_r_d = product;
    end else if (accum) begin
      acc_d   = acc_next;
      max_r_d = max_next;
      if (finish) begin
        sum_d     = acc_next;
        avg_d     = acc_next[SUM_W-1:LOG2_COUNT];
        max_out_d = max_next;
      end
    end
  end

  // Datapath registers; statistics survive clear and only change on frame completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q     <= '0;
      max_r_q   <= '0;
      sum_q     <= '0;
      avg_q     <= '0;
      max_out_q <= '0;
    end else begin
      acc_q     <= acc_d;
      max_r_q   <= max_r_d;
      sum_q     <= sum_d;
      avg_q     <= avg_d;
      max_out_q <= max_out_d;
    end
  end

  assign sum   = sum_q;
  assign avg   = avg_q;
  assign max_o = max_out_q;

endmodule

// File: rtl/product_frame_accumulator.sv
// rtl/product_frame_accumulator.sv - frame FSM and handshake accumulating COUNT products into sum/avg/max
module product_frame_accumulator
  import product_frame_accumulator_pkg::*;
#(
  parameter  int COUNT      = COUNT_DEFAULT,
  localparam int LOG2_COUNT = $clog2(COUNT),
  localparam int SUM_W      = sum_width(LOG2_COUNT)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       product,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SUM_W-1:0] sum,
  output logic [7:0]       avg,
  output logic [7:0]       max,
  output logic             busy
);

  localparam logic [LOG2_COUNT:0] COUNT_ONE  = (LOG2_COUNT+1)'(1);
  localparam logic [LOG2_COUNT:0] COUNT_LAST = (LOG2_COUNT+1)'(COUNT - 1);

  state_e               state_q, state_d;
  logic [LOG2_COUNT:0]  count_q, count_d;
  logic                 out_valid_q, out_valid_d;
  logic                 busy_q, busy_d;
  logic                 ready_en_q, ready_en_d;

  logic accept;
  logic dp_load, dp_accum, dp_finish, dp_restart;

  // ready_en keeps in_ready low until the first edge after reset release.
  assign in_ready = ready_en_q && (state_q != DONE);
  assign accept   = in_valid && in_ready;

  // Next-state, counter and datapath control decode; clear overrides everything.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    out_valid_d = out_valid_q;
    ready_en_d  = 1'b1;
    dp_load     = 1'b0;
    dp_accum    = 1'b0;
    dp_finish   = 1'b0;
    dp_restart  = 1'b0;

    if (clear) begin
      state_d     = IDLE;
      count_d     = '0;
      out_valid_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            dp_load = 1'b1;
            count_d = COUNT_ONE;
            state_d = ACCUM;
          end
        end
        ACCUM: begin
          if (accept) begin
            dp_accum = 1'b1;
            count_d  = count_q + COUNT_ONE;
            if (count_q == COUNT_LAST) begin
              dp_finish   = 1'b1;
              state_d     = DONE;
              out_valid_d = 1'b1;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            dp_restart  = 1'b1;
            out_valid_d = 1'b0;
            count_d     = '0;
            state_d     = IDLE;
          end
        end
        default: begin
          state_d     = IDLE;
          count_d     = '0;
          out_valid_d = 1'b0;
        end
      endcase
    end

    busy_d = (state_d != IDLE);
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      ready_en_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      ready_en_q  <= ready_en_d;
    end
  end

  frame_stat_datapath #(
    .LOG2_COUNT (LOG2_COUNT),
    .SUM_W      (SUM_W)
  ) u_datapath (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (clear),
    .load    (dp_load),
    .accum   (dp_accum),
    .finish  (dp_finish),
    .restart (dp_restart),
    .product (product),
    .sum     (sum),
    .avg     (avg),
    .max_o   (max)
  );

  assign out_valid = out_valid_q;
  assign busy      = busy_q;

endmodule
